// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: opcodes, branch-prediction record, resolver FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  // Prediction record produced at IF and carried down with the instruction.
  // predicted: the predictor had an entry for this PC.
  // prediction: predicted direction; brp_target: PC that fetch followed.
  typedef struct packed {
    logic        predicted;
    logic        prediction;
    logic [31:0] brp_target;
  } rv32i_brp_word;

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    SQUASH
  } br_resolve_state_t;

  localparam int BR_SQUASH_DEFAULT = 2;

endpackage

// File: rtl/br_resolve_if.sv
// Resolver-to-fetch/predictor bundle: redirect handshake plus training pulse.
// Latency: n/a (wiring only).
// Backpressure: redirect is valid/ready; the training pulse has no backpressure.
interface br_resolve_if;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_mispredicted;

  modport master (
    output redirect_valid, redirect_pc,
    output upd_valid, upd_pc, upd_taken, upd_mispredicted,
    input  redirect_ready
  );

  modport slave (
    input  redirect_valid, redirect_pc,
    input  upd_valid, upd_pc, upd_taken, upd_mispredicted,
    output redirect_ready
  );
endinterface

// File: rtl/br_resolve_check.sv
// Combinational compare of a carried prediction against the actual outcome of a control-flow op.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module br_check
  import rv32i_types::*;
(
  input  rv32i_opcode   opcode,
  input  logic [31:0]   pc,
  input  rv32i_brp_word brp,
  input  logic          br_en,
  input  logic [31:0]   br_target,
  output logic [31:0]   correct_pc,
  output logic          mispredict,
  output logic          resolvable,
  output logic          trainable
);

  logic [31:0] pc_seq;
  assign pc_seq = pc + 32'd4;

  // Correct next PC and mispredict per control-flow opcode; jalr is never predicted.
  always_comb begin
    correct_pc = pc_seq;
    mispredict = 1'b0;
    resolvable = 1'b0;
    trainable  = 1'b0;
    case (opcode)
      op_br: begin
        correct_pc = br_en ? br_target : pc_seq;
        mispredict = (brp.prediction != br_en) || (brp.brp_target != correct_pc);
        resolvable = 1'b1;
        trainable  = brp.predicted;
      end
      op_jal: begin
        correct_pc = br_target;
        mispredict = (brp.brp_target != br_target);
        resolvable = 1'b1;
      end
      op_jalr: begin
        correct_pc = {br_target[31:1], 1'b0};
        mispredict = 1'b1;
        resolvable = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/br_resolve.sv
// EX-stage branch resolution: redirect fetch on mispredict, flush younger stages, train predictor.
// Latency: redirect/flush/training outputs appear 1 cycle after resolution; flush lasts SQUASH_CYCLES after handshake.
// Backpressure: redirect held stable until redirect_ready; EX stalled and wrong-path ex_valid ignored meanwhile.
// Optional: BR_RESOLVE_STATS_EN enables the c_total/c_correct accuracy counters (tied to 0 otherwise).
module br_resolve
  import rv32i_types::*;
#(
  parameter int SQUASH_CYCLES = BR_SQUASH_DEFAULT,
  parameter int CNT_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  rv32i_opcode       ex_opcode,
  input  logic [31:0]       ex_pc,
  input  rv32i_brp_word     brp_ex,
  input  logic              br_en,
  input  logic [31:0]       br_target,
  br_resolve_if.master      fe,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              stall_ex,
  output logic [CNT_W-1:0]  c_total,
  output logic [CNT_W-1:0]  c_correct
);

  localparam logic [3:0] SQ_LOAD = 4'(SQUASH_CYCLES - 1);

  br_resolve_state_t state, state_nxt;
  logic [3:0]  sq_cnt, sq_cnt_nxt;
  logic [31:0] correct_pc;
  logic        mispredict, resolvable, trainable;
  logic        fire, train_evt;
  logic [31:0] redirect_pc_q;
  logic        upd_valid_q, upd_taken_q, upd_mis_q;
  logic [31:0] upd_pc_q;

  br_check u_check (
    .opcode     (ex_opcode),
    .pc         (ex_pc),
    .brp        (brp_ex),
    .br_en      (br_en),
    .br_target  (br_target),
    .correct_pc (correct_pc),
    .mispredict (mispredict),
    .resolvable (resolvable),
    .trainable  (trainable)
  );

  // Only IDLE resolves; anything in EX during REDIRECT/SQUASH is wrong-path.
  assign fire      = ex_valid && resolvable && (state == IDLE);
  assign train_evt = fire && trainable;

  // State and squash counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sq_cnt <= 4'd0;
    end else begin
      state  <= state_nxt;
      sq_cnt <= sq_cnt_nxt;
    end
  end

  // Next-state: redirect on mispredict, hold until accepted, then count out the squash window.
  always_comb begin
    state_nxt  = state;
    sq_cnt_nxt = sq_cnt;
    case (state)
      IDLE: begin
        if (fire && mispredict) state_nxt = REDIRECT;
      end
      REDIRECT: begin
        if (fe.redirect_ready) begin
          state_nxt  = SQUASH;
          sq_cnt_nxt = SQ_LOAD;
        end
      end
      SQUASH: begin
        if (sq_cnt == 4'd0) state_nxt = IDLE;
        else                sq_cnt_nxt = sq_cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the corrected PC at resolution so it stays stable while fetch stalls.
  always_ff @(posedge clk) begin
    if (rst)                     redirect_pc_q <= 32'd0;
    else if (fire && mispredict) redirect_pc_q <= correct_pc;
  end

  // One-cycle training pulse for predicted conditional branches.
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_valid_q <= 1'b0;
      upd_pc_q    <= 32'd0;
      upd_taken_q <= 1'b0;
      upd_mis_q   <= 1'b0;
    end else begin
      upd_valid_q <= train_evt;
      if (train_evt) begin
        upd_pc_q    <= ex_pc;
        upd_taken_q <= br_en;
        upd_mis_q   <= mispredict;
      end
    end
  end

  assign fe.redirect_valid   = (state == REDIRECT);
  assign fe.redirect_pc      = redirect_pc_q;
  assign fe.upd_valid        = upd_valid_q;
  assign fe.upd_pc           = upd_pc_q;
  assign fe.upd_taken        = upd_taken_q;
  assign fe.upd_mispredicted = upd_mis_q;
  assign flush_if_id         = (state != IDLE);
  assign flush_id_ex         = (state != IDLE);
  assign stall_ex            = (state != IDLE);

`ifdef BR_RESOLVE_STATS_EN
  logic [CNT_W-1:0] tot_q, cor_q;

  // Saturating accuracy counters over the same events that train the predictor.
  always_ff @(posedge clk) begin
    if (rst) begin
      tot_q <= '0;
      cor_q <= '0;
    end else if (train_evt) begin
      if (tot_q != '1)                tot_q <= tot_q + 1'b1;
      if (!mispredict && cor_q != '1) cor_q <= cor_q + 1'b1;
    end
  end

  assign c_total   = tot_q;
  assign c_correct = cor_q;
`else
  assign c_total   = '0;
  assign c_correct = '0;
`endif

endmodule

// File: tb/tb_br_resolve.sv
// Self-checking bench for br_resolve: vector table plus hand sequences, training pulses scoreboarded.
// Latency: n/a (testbench).
// Backpressure: bench drives redirect_ready to exercise the hold path.
module tb_br_resolve;
  import rv32i_types::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid;
  rv32i_opcode   ex_opcode;
  logic [31:0]   ex_pc;
  rv32i_brp_word brp_ex;
  logic          br_en;
  logic [31:0]   br_target;
  logic          flush_if_id, flush_id_ex, stall_ex;
  logic [CW-1:0] c_total, c_correct;

  br_resolve_if fe_if ();

  br_resolve #(.SQUASH_CYCLES(2), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_opcode   (ex_opcode),
    .ex_pc       (ex_pc),
    .brp_ex      (brp_ex),
    .br_en       (br_en),
    .br_target   (br_target),
    .fe          (fe_if.master),
    .flush_if_id (flush_if_id),
    .flush_id_ex (flush_id_ex),
    .stall_ex    (stall_ex),
    .c_total     (c_total),
    .c_correct   (c_correct)
  );

  always #5 clk = ~clk;

  typedef struct {
    rv32i_opcode op;
    logic [31:0] pc;
    logic        predicted;
    logic        prediction;
    logic [31:0] brp_target;
    logic        br_en;
    logic [31:0] br_target;
    logic        exp_redir;
    logic [31:0] exp_rpc;
    logic        exp_upd;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic        mis;
  } upd_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   m_tot = 0;
  int   m_cor = 0;
  upd_t sb_q[$];
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] cexp(input int v);
`ifdef BR_RESOLVE_STATS_EN
    return 32'(v);
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input rv32i_opcode op, input logic [31:0] pc, input logic pd, input logic pr,
                       input logic [31:0] bt, input logic en, input logic [31:0] tg, input logic v);
    ex_opcode  = op;
    ex_pc      = pc;
    brp_ex     = '{predicted: pd, prediction: pr, brp_target: bt};
    br_en      = en;
    br_target  = tg;
    ex_valid   = v;
  endtask

  // Expected training pulse and saturating counter model for a trained branch.
  task automatic expect_train(input logic [31:0] pc, input logic taken, input logic mis);
    upd_t u;
    u.pc = pc; u.taken = taken; u.mis = mis;
    sb_q.push_back(u);
    if (m_tot < 15) m_tot++;
    if (!mis && m_cor < 15) m_cor++;
  endtask

  task automatic chk_cnt(input string nm);
    chk({nm, "_c_total"}, 32'(c_total), cexp(m_tot));
    chk({nm, "_c_correct"}, 32'(c_correct), cexp(m_cor));
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    drive(v.op, v.pc, v.predicted, v.prediction, v.brp_target, v.br_en, v.br_target, 1'b1);
    if (v.exp_upd) expect_train(v.pc, v.br_en, v.exp_mis);
    tick();
    ex_valid = 1'b0;
    chk({nm, "_redirect_valid"}, 32'(fe_if.redirect_valid), 32'(v.exp_redir));
    chk({nm, "_flush_if_id"}, 32'(flush_if_id), 32'(v.exp_redir));
    chk({nm, "_stall_ex"}, 32'(stall_ex), 32'(v.exp_redir));
    if (v.exp_redir) begin
      chk({nm, "_redirect_pc"}, fe_if.redirect_pc, v.exp_rpc);
      fe_if.redirect_ready = 1'b1;
      tick();
      fe_if.redirect_ready = 1'b0;
      chk({nm, "_sq1_redirect_valid"}, 32'(fe_if.redirect_valid), 32'd0);
      chk({nm, "_sq1_flush_id_ex"}, 32'(flush_id_ex), 32'd1);
      tick();
      chk({nm, "_sq2_flush_if_id"}, 32'(flush_if_id), 32'd1);
      tick();
      chk({nm, "_idle_flush_if_id"}, 32'(flush_if_id), 32'd0);
      chk({nm, "_idle_stall_ex"}, 32'(stall_ex), 32'd0);
    end else begin
      tick();
    end
    chk_cnt(nm);
  endtask

  // Scoreboard: every training pulse must match the oldest expected one.
  always @(negedge clk) begin
    if (fe_if.upd_valid === 1'b1) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL upd_unexpected: got pulse pc %h expected none", fe_if.upd_pc);
      end else begin
        upd_t e;
        e = sb_q.pop_front();
        if (fe_if.upd_pc !== e.pc || fe_if.upd_taken !== e.taken || fe_if.upd_mispredicted !== e.mis) begin
          n_err++;
          $display("FAIL upd_fields: got pc %h taken %b mis %b expected pc %h taken %b mis %b",
                   fe_if.upd_pc, fe_if.upd_taken, fe_if.upd_mispredicted, e.pc, e.taken, e.mis);
        end
      end
    end
  end

  initial begin
    //          op      pc        pd    pr    brp_tgt   en    tgt       redir rpc       upd   mis
    tbl[0] = '{op_br,   32'h100, 1'b1, 1'b1, 32'h140, 1'b1, 32'h140, 1'b0, 32'h0,   1'b1, 1'b0};
    tbl[1] = '{op_br,   32'h180, 1'b1, 1'b0, 32'h184, 1'b0, 32'h1c0, 1'b0, 32'h0,   1'b1, 1'b0};
    tbl[2] = '{op_br,   32'h1a0, 1'b1, 1'b1, 32'h1e0, 1'b1, 32'h1f0, 1'b1, 32'h1f0, 1'b1, 1'b1};
    tbl[3] = '{op_br,   32'h1c0, 1'b1, 1'b0, 32'h1c4, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 1'b1};
    tbl[4] = '{op_jal,  32'h240, 1'b1, 1'b1, 32'h280, 1'b0, 32'h280, 1'b0, 32'h0,   1'b0, 1'b0};
    tbl[5] = '{op_jal,  32'h250, 1'b0, 1'b0, 32'h254, 1'b0, 32'h300, 1'b1, 32'h300, 1'b0, 1'b0};
    tbl[6] = '{op_jalr, 32'h300, 1'b0, 1'b0, 32'h304, 1'b0, 32'h401, 1'b1, 32'h400, 1'b0, 1'b0};
    tbl[7] = '{op_reg,  32'h310, 1'b1, 1'b1, 32'h999, 1'b1, 32'h888, 1'b0, 32'h0,   1'b0, 1'b0};
    tbl[8] = '{op_br,   32'h320, 1'b0, 1'b0, 32'h324, 1'b0, 32'h360, 1'b0, 32'h0,   1'b0, 1'b0};
    tbl[9] = '{op_br,   32'h330, 1'b0, 1'b0, 32'h334, 1'b1, 32'h380, 1'b1, 32'h380, 1'b0, 1'b0};

    rst = 1'b1;
    fe_if.redirect_ready = 1'b0;
    drive(op_reg, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_redirect_valid", 32'(fe_if.redirect_valid), 32'd0);
    chk("rst_redirect_pc", fe_if.redirect_pc, 32'd0);
    chk("rst_flush_if_id", 32'(flush_if_id), 32'd0);
    chk("rst_flush_id_ex", 32'(flush_id_ex), 32'd0);
    chk("rst_stall_ex", 32'(stall_ex), 32'd0);
    chk("rst_upd_valid", 32'(fe_if.upd_valid), 32'd0);
    chk_cnt("rst");

    for (int i = 0; i < 10; i++) apply_vec(tbl[i], i);

    // Not-taken mispredict, redirect held 3 cycles, wrong-path mispredicting branch in EX throughout.
    drive(op_br, 32'h200, 1'b1, 1'b1, 32'h240, 1'b0, 32'h240, 1'b1);
    expect_train(32'h200, 1'b0, 1'b1);
    tick();
    drive(op_br, 32'h500, 1'b1, 1'b1, 32'h600, 1'b1, 32'h700, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("hold%0d_redirect_valid", i), 32'(fe_if.redirect_valid), 32'd1);
      chk($sformatf("hold%0d_redirect_pc", i), fe_if.redirect_pc, 32'h204);
      chk($sformatf("hold%0d_flush_id_ex", i), 32'(flush_id_ex), 32'd1);
      chk($sformatf("hold%0d_stall_ex", i), 32'(stall_ex), 32'd1);
      if (i < 3) tick();
    end
    fe_if.redirect_ready = 1'b1;
    tick();
    fe_if.redirect_ready = 1'b0;
    chk("hold_sq1_redirect_valid", 32'(fe_if.redirect_valid), 32'd0);
    chk("hold_sq1_flush_if_id", 32'(flush_if_id), 32'd1);
    tick();
    chk("hold_sq2_flush_if_id", 32'(flush_if_id), 32'd1);
    chk("hold_sq2_stall_ex", 32'(stall_ex), 32'd1);
    tick();
    ex_valid = 1'b0;
    chk("hold_idle_flush_if_id", 32'(flush_if_id), 32'd0);
    chk("hold_idle_redirect_valid", 32'(fe_if.redirect_valid), 32'd0);
    tick();
    chk("hold_after_redirect_valid", 32'(fe_if.redirect_valid), 32'd0);
    chk_cnt("hold");

    // Reset while a redirect is pending abandons it.
    drive(op_jalr, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0, 32'h401, 1'b1);
    tick();
    ex_valid = 1'b0;
    chk("mid_redirect_valid", 32'(fe_if.redirect_valid), 32'd1);
    chk("mid_redirect_pc", fe_if.redirect_pc, 32'h400);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_tot = 0;
    m_cor = 0;
    chk("mrst_redirect_valid", 32'(fe_if.redirect_valid), 32'd0);
    chk("mrst_redirect_pc", fe_if.redirect_pc, 32'd0);
    chk("mrst_flush_if_id", 32'(flush_if_id), 32'd0);
    chk("mrst_stall_ex", 32'(stall_ex), 32'd0);
    chk_cnt("mrst");
    apply_vec(tbl[0], 100);

    // Back-to-back correct predicted branches: one pulse each.
    for (int i = 0; i < 3; i++) begin
      drive(op_br, 32'h600 + 32'(i * 8), 1'b1, 1'b1, 32'h700, 1'b1, 32'h700, 1'b1);
      expect_train(32'h600 + 32'(i * 8), 1'b1, 1'b0);
      tick();
      chk($sformatf("b2b%0d_redirect_valid", i), 32'(fe_if.redirect_valid), 32'd0);
    end
    ex_valid = 1'b0;
    tick();
    chk("b2b_sb_drained", 32'(sb_q.size()), 32'd0);
    chk_cnt("b2b");

    // Saturation: 20 more correct branches.
    for (int i = 0; i < 20; i++) begin
      drive(op_br, 32'h800 + 32'(i * 4), 1'b1, 1'b0, 32'h804 + 32'(i * 4), 1'b0, 32'h900, 1'b1);
      expect_train(32'h800 + 32'(i * 4), 1'b0, 1'b0);
      tick();
    end
    ex_valid = 1'b0;
    tick();
    chk_cnt("sat");
    tick();
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
